// File: rtl/axi_w_router_if.sv
// AW-route and W-channel bundle between one AXI master and the write-data router.
// Suffixes are named from the router's point of view.
interface axi_w_router_if #(
    parameter int NUM_S  = 3,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic                      aw_push_i;
    logic [NUM_S-1:0]          aw_sel_i;
    logic [3:0]                aw_len_i;
    logic                      aw_ready_o;
    logic [DATA_W-1:0]         wdata_m_i;
    logic [STRB_W-1:0]         wstrb_m_i;
    logic                      wlast_m_i;
    logic                      wvalid_m_i;
    logic                      wready_m_o;
    logic [NUM_S*DATA_W-1:0]   wdata_s_o;
    logic [NUM_S*STRB_W-1:0]   wstrb_s_o;
    logic [NUM_S-1:0]          wlast_s_o;
    logic [NUM_S-1:0]          wvalid_s_o;
    logic [NUM_S-1:0]          wready_s_i;
    logic                      dec_err_o;
    logic                      last_err_o;
    logic [CNT_W-1:0]          outstanding_o;

    modport slave (
        input  aw_push_i, aw_sel_i, aw_len_i,
        input  wdata_m_i, wstrb_m_i, wlast_m_i, wvalid_m_i, wready_s_i,
        output aw_ready_o, wready_m_o, wdata_s_o, wstrb_s_o, wlast_s_o, wvalid_s_o,
        output dec_err_o, last_err_o, outstanding_o
    );

    modport master (
        output aw_push_i, aw_sel_i, aw_len_i,
        output wdata_m_i, wstrb_m_i, wlast_m_i, wvalid_m_i, wready_s_i,
        input  aw_ready_o, wready_m_o, wdata_s_o, wstrb_s_o, wlast_s_o, wvalid_s_o,
        input  dec_err_o, last_err_o, outstanding_o
    );
endinterface

// File: rtl/axi_w_router.sv
// Steers AXI W beats to the slave chosen by the matching AW, using an in-order route FIFO.
// Decode-error bursts are sunk locally; WLAST/AWLEN disagreements are flagged.
module axi_w_router #(
    parameter int NUM_S  = 3,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic           clk,
    input  logic           rst,
    axi_w_router_if.slave  bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic [NUM_S-1:0] sel_mem [DEPTH];
    logic [3:0]       len_mem [DEPTH];

    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       beat_q, beat_d;
    logic             dec_err_q, dec_err_d, last_err_q, last_err_d;

    logic             empty, full, push, pop, hs, sel_onehot, wready_m;
    logic [NUM_S-1:0] head_sel, push_sel;
    logic [3:0]       head_len;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CNT_W'(DEPTH));
    assign head_sel = empty ? '0 : sel_mem[rptr_q];
    assign head_len = len_mem[rptr_q];

    // Multi-hot selects are stored as all-zero so they follow the decode-error path.
    assign sel_onehot = (bus.aw_sel_i != '0) &&
                        ((bus.aw_sel_i & (bus.aw_sel_i - NUM_S'(1))) == '0);
    assign push_sel   = sel_onehot ? bus.aw_sel_i : '0;

    always_comb begin
        wready_m = 1'b0;
        if (!empty) begin
            wready_m = (head_sel == '0) ? 1'b1 : |(head_sel & bus.wready_s_i);
        end
    end

    assign hs  = bus.wvalid_m_i & wready_m;
    assign pop = hs & bus.wlast_m_i;
    // A full FIFO still takes a push when the head retires in the same cycle.
    assign push = bus.aw_push_i & (!full | pop);

    assign bus.aw_ready_o    = !full;
    assign bus.outstanding_o = cnt_q;
    assign bus.wready_m_o    = wready_m;
    assign bus.wvalid_s_o    = head_sel & {NUM_S{bus.wvalid_m_i}};
    assign bus.wlast_s_o     = {NUM_S{bus.wlast_m_i}};
    assign bus.dec_err_o     = dec_err_q;
    assign bus.last_err_o    = last_err_q;

    for (genvar i = 0; i < NUM_S; i++) begin : g_slice
        assign bus.wdata_s_o[i*DATA_W +: DATA_W] = bus.wdata_m_i;
        assign bus.wstrb_s_o[i*STRB_W +: STRB_W] = head_sel[i] ? bus.wstrb_m_i : '1;
    end

    always_comb begin
        wptr_d = wptr_q + PTR_W'(push);
        rptr_d = rptr_q + PTR_W'(pop);
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        beat_d = beat_q;
        if (pop) begin
            beat_d = '0;
        end else if (hs) begin
            beat_d = beat_q + 4'd1;
        end
        last_err_d = hs & (bus.wlast_m_i ? (beat_q != head_len) : (beat_q == head_len));
        dec_err_d  = pop & (head_sel == '0);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            sel_mem[wptr_q] <= push_sel;
            len_mem[wptr_q] <= bus.aw_len_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            beat_q     <= '0;
            dec_err_q  <= 1'b0;
            last_err_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            beat_q     <= beat_d;
            dec_err_q  <= dec_err_d;
            last_err_q <= last_err_d;
        end
    end
endmodule

// File: tb/tb_axi_w_router.sv
// Directed bench for axi_w_router: routing, FIFO full/wrap, decode and WLAST errors, async reset.
module tb_axi_w_router;
    logic clk;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    axi_w_router_if #(.NUM_S(3), .DATA_W(32), .DEPTH(4)) bus ();

    axi_w_router #(.NUM_S(3), .DATA_W(32), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] sel, input logic [3:0] len);
        bus.aw_push_i = 1'b1;
        bus.aw_sel_i  = sel;
        bus.aw_len_i  = len;
        tick();
        bus.aw_push_i = 1'b0;
    endtask

    // Drives nbeats with WLAST on the final one and checks routing of every beat.
    task automatic burst(input logic [2:0] sel_exp, input int nbeats, input string tag);
        logic [11:0] exp_strb;
        for (int i = 0; i < 3; i++) exp_strb[i*4 +: 4] = sel_exp[i] ? 4'h3 : 4'hF;
        for (int k = 0; k < nbeats; k++) begin
            bus.wvalid_m_i = 1'b1;
            bus.wlast_m_i  = (k == nbeats - 1);
            bus.wdata_m_i  = 32'hC0DE_0000 + k;
            bus.wstrb_m_i  = 4'h3;
            #1;
            chk({tag, "_wvalid_s"}, bus.wvalid_s_o, sel_exp);
            chk({tag, "_wready_m"}, bus.wready_m_o, 1'b1);
            chk({tag, "_wstrb_s"},  bus.wstrb_s_o, exp_strb);
            chk({tag, "_wdata_s2"}, bus.wdata_s_o[95:64], 32'hC0DE_0000 + k);
            chk({tag, "_wlast_s"},  bus.wlast_s_o, (k == nbeats - 1) ? 3'b111 : 3'b000);
            tick();
        end
        bus.wvalid_m_i = 1'b0;
        bus.wlast_m_i  = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        bus.aw_push_i  = 1'b0;
        bus.aw_sel_i   = '0;
        bus.aw_len_i   = '0;
        bus.wdata_m_i  = '0;
        bus.wstrb_m_i  = '0;
        bus.wlast_m_i  = 1'b0;
        bus.wvalid_m_i = 1'b0;
        bus.wready_s_i = 3'b111;
        tick();
        tick();
        chk("rst_aw_ready", bus.aw_ready_o, 1'b1);
        chk("rst_outst",    bus.outstanding_o, 3'd0);
        chk("rst_wvalid_s", bus.wvalid_s_o, 3'b000);
        chk("rst_wready_m", bus.wready_m_o, 1'b0);
        chk("rst_dec_err",  bus.dec_err_o, 1'b0);
        chk("rst_last_err", bus.last_err_o, 1'b0);
        rst = 1'b1;
        tick();

        // Empty FIFO never accepts; a pushed route is usable one cycle later.
        bus.wvalid_m_i = 1'b1;
        #1;
        chk("empty_wready_m", bus.wready_m_o, 1'b0);
        chk("empty_wvalid_s", bus.wvalid_s_o, 3'b000);
        push(3'b010, 4'd3);
        chk("b1_outst", bus.outstanding_o, 3'd1);
        chk("b1_head_vld", bus.wvalid_s_o, 3'b010);
        bus.wready_s_i = 3'b101;
        #1;
        chk("b1_bp_wready_m", bus.wready_m_o, 1'b0);
        bus.wready_s_i = 3'b111;
        burst(3'b010, 4, "b1");
        chk("b1_outst_end", bus.outstanding_o, 3'd0);
        chk("b1_last_err",  bus.last_err_o, 1'b0);
        chk("b1_dec_err",   bus.dec_err_o, 1'b0);
        chk("b1_idle_vld",  bus.wvalid_s_o, 3'b000);
        chk("b1_idle_rdy",  bus.wready_m_o, 1'b0);

        // Fill to DEPTH, then an ignored push.
        push(3'b001, 4'd0);
        push(3'b010, 4'd0);
        push(3'b100, 4'd0);
        push(3'b001, 4'd1);
        chk("full_aw_ready", bus.aw_ready_o, 1'b0);
        chk("full_outst",    bus.outstanding_o, 3'd4);
        push(3'b100, 4'd0);
        chk("full_ign_outst", bus.outstanding_o, 3'd4);

        // Full FIFO: push and last-beat pop together.
        bus.aw_push_i  = 1'b1;
        bus.aw_sel_i   = 3'b010;
        bus.aw_len_i   = 4'd2;
        bus.wvalid_m_i = 1'b1;
        bus.wlast_m_i  = 1'b1;
        #1;
        chk("pp_head_vld", bus.wvalid_s_o, 3'b001);
        tick();
        bus.aw_push_i  = 1'b0;
        bus.wvalid_m_i = 1'b0;
        bus.wlast_m_i  = 1'b0;
        chk("pp_outst",    bus.outstanding_o, 3'd4);
        chk("pp_last_err", bus.last_err_o, 1'b0);
        burst(3'b010, 1, "q1");
        burst(3'b100, 1, "q2");
        burst(3'b001, 2, "q3");
        burst(3'b010, 3, "q4");
        chk("drain_outst",    bus.outstanding_o, 3'd0);
        chk("drain_last_err", bus.last_err_o, 1'b0);

        // Decode errors: zero select sinks beats even with no slave ready; multi-hot too.
        bus.wready_s_i = 3'b000;
        push(3'b000, 4'd1);
        burst(3'b000, 2, "de0");
        chk("de0_pulse", bus.dec_err_o, 1'b1);
        tick();
        chk("de0_clear", bus.dec_err_o, 1'b0);
        push(3'b011, 4'd0);
        burst(3'b000, 1, "de3");
        chk("de3_pulse", bus.dec_err_o, 1'b1);
        tick();
        chk("de3_clear", bus.dec_err_o, 1'b0);
        bus.wready_s_i = 3'b111;

        // Early WLAST: burst ends, error flagged, next route takes over.
        push(3'b001, 4'd3);
        push(3'b100, 4'd0);
        bus.wvalid_m_i = 1'b1;
        bus.wlast_m_i  = 1'b0;
        tick();
        bus.wlast_m_i  = 1'b1;
        #1;
        chk("el_vld", bus.wvalid_s_o, 3'b001);
        tick();
        bus.wvalid_m_i = 1'b0;
        bus.wlast_m_i  = 1'b0;
        chk("el_pulse", bus.last_err_o, 1'b1);
        chk("el_outst", bus.outstanding_o, 3'd1);
        tick();
        chk("el_clear", bus.last_err_o, 1'b0);
        burst(3'b100, 1, "el_next");
        chk("el_next_err", bus.last_err_o, 1'b0);

        // Missing WLAST at len, then late WLAST: two consecutive pulses.
        push(3'b001, 4'd0);
        bus.wvalid_m_i = 1'b1;
        bus.wlast_m_i  = 1'b0;
        tick();
        chk("ml_pulse1", bus.last_err_o, 1'b1);
        bus.wlast_m_i  = 1'b1;
        tick();
        bus.wvalid_m_i = 1'b0;
        bus.wlast_m_i  = 1'b0;
        chk("ml_pulse2", bus.last_err_o, 1'b1);
        chk("ml_outst",  bus.outstanding_o, 3'd0);
        tick();
        chk("ml_clear", bus.last_err_o, 1'b0);

        // Async reset mid-burst with two routes queued.
        push(3'b010, 4'd3);
        push(3'b100, 4'd0);
        bus.wvalid_m_i = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("ar_outst",    bus.outstanding_o, 3'd0);
        chk("ar_wvalid_s", bus.wvalid_s_o, 3'b000);
        chk("ar_wready_m", bus.wready_m_o, 1'b0);
        chk("ar_aw_ready", bus.aw_ready_o, 1'b1);
        tick();
        rst = 1'b1;
        #1;
        chk("ar_post_vld", bus.wvalid_s_o, 3'b000);
        chk("ar_post_rdy", bus.wready_m_o, 1'b0);
        bus.wvalid_m_i = 1'b0;
        tick();
        push(3'b100, 4'd0);
        burst(3'b100, 1, "ar_new");
        chk("ar_new_err",   bus.last_err_o, 1'b0);
        chk("ar_new_outst", bus.outstanding_o, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
